// File: rtl/prog_sequencer.sv
// prog_sequencer
// Program sequencer for the 9-bit bus processor. Reads instruction words from a
// synchronous program ROM and hands them to the processor on DIN, holding Run
// high until the processor reports Done. For mvi the immediate word is fetched
// ahead of issue so DIN can switch to it in the processor's T1 step. A watchdog
// bounds how long an instruction may execute, and a reserved word halts the run.
module prog_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter logic [2:0]  MVI_OP    = 3'b001,
    parameter logic [8:0]  HALT_WORD = 9'b111111111,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [8:0]        rom_data,
    output logic [8:0]        DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        instr_count
);

    // Wide enough to hold TIMEOUT itself.
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_I,
        S_LATCH_I,
        S_FETCH_M,
        S_LATCH_M,
        S_ISSUE,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t state;
    state_t next_state;

    // Instruction word, its immediate (mvi only) and the decoded mvi flag.
    logic [8:0]        instr;
    logic [8:0]        imm;
    logic              is_mvi;

    // Cycles spent in EXEC for the current instruction.
    logic [WD_W-1:0]   wd;

    // Next values of the registered processor-facing outputs.
    logic [8:0]        din_d;
    logic              run_d;
    logic              busy_d;
    logic              halted_d;
    logic              error_d;

    logic              wd_expired;
    logic              fetch_is_halt;
    logic              fetch_is_mvi;
    logic [ADDR_W-1:0] pc_step;

    // The increment on this cycle would bring the watchdog to TIMEOUT.
    assign wd_expired    = (wd == WD_W'(TIMEOUT - 1));
    assign fetch_is_halt = (rom_data == HALT_WORD);
    assign fetch_is_mvi  = (rom_data[8:6] == MVI_OP);
    // An mvi occupies two ROM words, so it advances pc by two.
    assign pc_step       = is_mvi ? ADDR_W'(2) : ADDR_W'(1);

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering in simulation.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; Abort overrides every other request.
    // NOTE: each combinational block assigns its outputs a default first so that no
    // path through the case statements leaves a value unassigned (no latches).
    always_comb begin
        next_state = state;
        if (Abort) begin
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (Start) begin
                        next_state = S_FETCH_I;
                    end
                end
                S_FETCH_I: next_state = S_LATCH_I;
                S_LATCH_I: begin
                    if (fetch_is_halt) begin
                        next_state = S_HALTED;
                    end else if (fetch_is_mvi) begin
                        next_state = S_FETCH_M;
                    end else begin
                        next_state = S_ISSUE;
                    end
                end
                S_FETCH_M: next_state = S_LATCH_M;
                S_LATCH_M: next_state = S_ISSUE;
                S_ISSUE:   next_state = S_EXEC;
                S_EXEC: begin
                    // Done wins over an expiring watchdog in the same cycle.
                    if (Done) begin
                        next_state = S_FETCH_I;
                    end else if (wd_expired) begin
                        next_state = S_ERROR;
                    end
                end
                default:   next_state = S_IDLE;
            endcase
        end
    end

    // Output decode: ROM address from state/pc, plus next values of the
    // registered outputs, so each output register tracks the state it enters.
    always_comb begin
        rom_addr = pc;
        din_d    = '0;
        run_d    = 1'b0;
        busy_d   = 1'b0;
        halted_d = 1'b0;
        error_d  = 1'b0;

        // The immediate sits in the word after the opcode, wrapping at the top.
        if (state == S_FETCH_M) begin
            rom_addr = pc + 1'b1;
        end

        run_d = (next_state == S_EXEC);
        if (run_d) begin
            // First Run cycle carries the opcode (T0); mvi then switches to the
            // immediate for the rest of EXEC.
            din_d = (state == S_ISSUE || !is_mvi) ? instr : imm;
        end

        busy_d   = !(next_state inside {S_IDLE, S_HALTED, S_ERROR});
        halted_d = (next_state == S_HALTED);
        error_d  = (next_state == S_ERROR);
    end

    // Registered processor-facing and status outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            DIN    <= '0;
            Run    <= 1'b0;
            Busy   <= 1'b0;
            Halted <= 1'b0;
            Error  <= 1'b0;
        end else begin
            DIN    <= din_d;
            Run    <= run_d;
            Busy   <= busy_d;
            Halted <= halted_d;
            Error  <= error_d;
        end
    end

    // Datapath: program counter, instruction count, fetched words and watchdog.
    // NOTE: the fetched-word registers are reset along with the control state; they
    // are only a few flops, and a known value keeps DIN clean after reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc          <= '0;
            instr_count <= '0;
            instr       <= '0;
            imm         <= '0;
            is_mvi      <= 1'b0;
            wd          <= '0;
        end else if (!Abort) begin
            unique case (state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (Start) begin
                        pc          <= '0;
                        instr_count <= '0;
                    end
                end
                S_LATCH_I: begin
                    instr  <= rom_data;
                    is_mvi <= fetch_is_mvi;
                end
                S_LATCH_M: begin
                    imm <= rom_data;
                end
                S_ISSUE: begin
                    wd <= '0;
                end
                S_EXEC: begin
                    wd <= wd + 1'b1;
                    if (Done) begin
                        pc <= pc + pc_step;
                        if (instr_count != 8'hFF) begin
                            instr_count <= instr_count + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Structural invariants of the outputs.
    a_run_busy : assert property (@(posedge Clock) disable iff (!Resetn) Run |-> Busy);
    a_status   : assert property (@(posedge Clock) disable iff (!Resetn) $onehot0({Busy, Halted, Error}));
    a_din_idle : assert property (@(posedge Clock) disable iff (!Resetn) !Run |-> (DIN == 9'h000));
    a_issue_1c : assert property (@(posedge Clock) disable iff (!Resetn)
                                  (state == S_ISSUE) |=> (state inside {S_EXEC, S_IDLE}));
    a_abort    : assert property (@(posedge Clock) disable iff (!Resetn) Abort |=> (state == S_IDLE));

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer
// Drives prog_sequencer with directed programs and randomized ROM contents and
// handshakes, comparing every output each cycle with a transaction-level model.
module tb_prog_sequencer;

    localparam int         AW      = 5;
    localparam int         TIMEOUT = 15;
    localparam logic [8:0] HALT    = 9'h1FF;
    localparam logic [2:0] MVI     = 3'b001;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Start;
    logic          Abort;
    logic          Done;
    logic [AW-1:0] rom_addr;
    logic [8:0]    rom_data;
    logic [8:0]    DIN;
    logic          Run;
    logic          Busy;
    logic          Halted;
    logic          Error;
    logic [AW-1:0] pc;
    logic [7:0]    instr_count;

    logic [8:0]    rom [32];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            auto_done;

    prog_sequencer #(
        .ADDR_W   (AW),
        .MVI_OP   (MVI),
        .HALT_WORD(HALT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .Abort      (Abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .DIN        (DIN),
        .Run        (Run),
        .Done       (Done),
        .Busy       (Busy),
        .Halted     (Halted),
        .Error      (Error),
        .pc         (pc),
        .instr_count(instr_count)
    );

    always #5 Clock = ~Clock;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge Clock) rom_data <= rom[rom_addr];

    // ---------------- behavioural model ----------------
    // Between instructions the sequencer is "in a gap" for a fixed number of cycles
    // (2 until a halt is seen, 3 before a plain instruction runs, 5 before an mvi),
    // then it runs until Done or until TIMEOUT run cycles have elapsed.
    typedef enum logic [2:0] {M_IDLE, M_GAP, M_RUN, M_HALT, M_ERR} mode_t;

    typedef struct packed {
        mode_t         mode;
        logic [3:0]    gap;
        logic [4:0]    run_cycles;
        logic [AW-1:0] pc;
        logic [7:0]    cnt;
        logic [8:0]    instr;
        logic [8:0]    imm;
        logic          mvi;
        logic          halt_next;
        logic [15:0]   completed;
    } model_t;

    model_t m;

    function automatic model_t fetch_next(model_t cur);
        model_t        n = cur;
        logic [8:0]    w;
        logic [AW-1:0] nxt;
        w           = rom[cur.pc];
        nxt         = cur.pc + 1'b1;
        n.instr     = w;
        n.imm       = rom[nxt];
        n.halt_next = (w == HALT);
        n.mvi       = !n.halt_next && (w[8:6] == MVI);
        n.gap       = n.halt_next ? 4'd2 : (n.mvi ? 4'd5 : 4'd3);
        n.mode      = M_GAP;
        return n;
    endfunction

    function automatic model_t step(model_t cur, logic st, logic ab, logic dn);
        model_t n = cur;
        if (ab) begin
            n.mode = M_IDLE;
        end else begin
            case (cur.mode)
                M_IDLE, M_HALT, M_ERR: begin
                    if (st) begin
                        n.pc  = '0;
                        n.cnt = '0;
                        n     = fetch_next(n);
                    end
                end
                M_GAP: begin
                    n.gap = cur.gap - 4'd1;
                    if (n.gap == 4'd0) begin
                        n.mode       = cur.halt_next ? M_HALT : M_RUN;
                        n.run_cycles = '0;
                    end
                end
                M_RUN: begin
                    n.run_cycles = cur.run_cycles + 5'd1;
                    if (dn) begin
                        n.pc        = cur.pc + (cur.mvi ? AW'(2) : AW'(1));
                        n.cnt       = (cur.cnt == 8'd255) ? 8'd255 : cur.cnt + 8'd1;
                        n.completed = cur.completed + 16'd1;
                        n           = fetch_next(n);
                    end else if (n.run_cycles == 5'(TIMEOUT)) begin
                        n.mode = M_ERR;
                    end
                end
                default: n.mode = M_IDLE;
            endcase
        end
        return n;
    endfunction

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) m <= '0;
        else         m <= step(m, Start, Abort, Done);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge, compare all outputs with the model,
    // then (in auto mode) choose Done for the coming rising edge.
    task automatic tick();
        logic       exp_run;
        logic [8:0] exp_din;
        @(negedge Clock);
        exp_run = (m.mode == M_RUN);
        exp_din = exp_run ? ((m.run_cycles == 5'd0 || !m.mvi) ? m.instr : m.imm) : 9'h000;
        check("cyc_run",    Run,         exp_run);
        check("cyc_din",    DIN,         exp_din);
        check("cyc_busy",   Busy,        (m.mode == M_GAP) || (m.mode == M_RUN));
        check("cyc_halted", Halted,      m.mode == M_HALT);
        check("cyc_error",  Error,       m.mode == M_ERR);
        check("cyc_pc",     pc,          m.pc);
        check("cyc_count",  instr_count, m.cnt);
        if (auto_done) begin
            if (m.mode == M_RUN) Done = ($urandom_range(0, 2) == 0) || (m.run_cycles >= 5'd6);
            else                 Done = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic wait_run(output int n);
        n = 0;
        do begin
            tick();
            Start = 1'b0;
            n++;
        end while (!Run && n < 50);
    endtask

    task automatic wait_stop(output int n);
        n = 0;
        do begin
            tick();
            Start = 1'b0;
            n++;
        end while (!Halted && !Error && n < 2000);
    endtask

    task automatic go_idle();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
    endtask

    initial begin
        int         n;
        int         k;
        int         r;
        logic [8:0] w;

        Resetn    = 1'b0;
        Start     = 1'b0;
        Abort     = 1'b0;
        Done      = 1'b0;
        auto_done = 1'b0;
        for (int a = 0; a < 32; a++) rom[a] = 9'h000;

        // Reset values.
        tick();
        check("rst_run",    Run,         0);
        check("rst_din",    DIN,         0);
        check("rst_busy",   Busy,        0);
        check("rst_halted", Halted,      0);
        check("rst_error",  Error,       0);
        check("rst_pc",     pc,          0);
        check("rst_count",  instr_count, 0);
        check("rst_romaddr", rom_addr,   0);
        #2 Resetn = 1'b1;

        // Plain instruction then HALT.
        rom[0] = 9'h008;
        rom[1] = HALT;
        Start = 1'b1;
        wait_run(n);
        check("t1_latency", n, 4);
        check("t1_din0", DIN, 9'h008);
        tick();
        check("t1_run1", Run, 1);
        check("t1_din1", DIN, 9'h008);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("t1_run_off", Run, 0);
        wait_stop(n);
        check("t1_halt_lat", n, 2);
        check("t1_halted", Halted, 1);
        check("t1_pc", pc, 1);
        check("t1_count", instr_count, 1);
        check("t1_model_pc", m.pc, 1);

        // mvi with immediate, then HALT.
        rom[0] = 9'h050;
        rom[1] = 9'h05A;
        rom[2] = HALT;
        Start = 1'b1;
        wait_run(n);
        check("t2_latency", n, 6);
        check("t2_din_op", DIN, 9'h050);
        tick();
        check("t2_din_imm_a", DIN, 9'h05A);
        tick();
        check("t2_din_imm_b", DIN, 9'h05A);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("t2_run_off", Run, 0);
        wait_stop(n);
        check("t2_halted", Halted, 1);
        check("t2_pc", pc, 2);
        check("t2_count", instr_count, 1);

        // Watchdog: Done never arrives.
        rom[0] = 9'h080;
        Start = 1'b1;
        wait_run(n);
        check("t3_latency", n, 4);
        k = 1;
        do begin
            tick();
            if (!Error) k++;
        end while (!Error && k < 40);
        check("t3_run_cycles", k, TIMEOUT);
        check("t3_error", Error, 1);
        check("t3_run_off", Run, 0);
        check("t3_busy", Busy, 0);
        check("t3_pc", pc, 0);
        check("t3_model_err", m.mode == M_ERR, 1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t3_err_clear", Error, 0);
        check("t3_restart_busy", Busy, 1);
        go_idle();

        // pc wrap: mvi at the last address takes its immediate from address 0.
        rom[0] = 9'h0AA;
        for (int a = 1; a < 31; a++) rom[a] = 9'h008;
        rom[31] = 9'h050;
        auto_done = 1'b1;
        Start = 1'b1;
        k = 0;
        do begin
            tick();
            Start = 1'b0;
            k++;
        end while (!(pc == 5'd31 && Run) && k < 2000);
        check("t4_reach_top", (pc == 5'd31) && Run, 1);
        auto_done = 1'b0;
        Done = 1'b0;
        check("t4_din_op", DIN, 9'h050);
        tick();
        check("t4_din_imm", DIN, 9'h0AA);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("t4_pc_wrap", pc, 1);
        check("t4_count", instr_count, 32);
        check("t4_model_count", m.cnt, 32);
        go_idle();

        // Abort beats Start in EXEC; a later Done is ignored.
        rom[0] = 9'h080;
        Start = 1'b1;
        wait_run(n);
        Abort = 1'b1;
        Start = 1'b1;
        tick();
        Abort = 1'b0;
        Start = 1'b0;
        check("t5_run", Run, 0);
        check("t5_busy", Busy, 0);
        check("t5_din", DIN, 0);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("t5_busy_after_done", Busy, 0);
        check("t5_count", instr_count, 0);
        check("t5_pc", pc, 0);

        // Randomized programs, handshakes, Start noise and rare Aborts.
        auto_done = 1'b1;
        for (int ep = 0; ep < 30; ep++) begin
            if (m.mode == M_GAP || m.mode == M_RUN) go_idle();
            for (int a = 0; a < 32; a++) begin
                r = $urandom_range(0, 15);
                if (r == 0)     rom[a] = HALT;
                else if (r < 5) rom[a] = {MVI, 6'($urandom)};
                else            rom[a] = 9'($urandom);
            end
            Start = 1'b1;
            tick();
            Start = 1'b0;
            for (int c = 0; c < 300; c++) begin
                if (m.mode != M_GAP && m.mode != M_RUN) break;
                Start = ($urandom_range(0, 15) == 0);
                Abort = ($urandom_range(0, 199) == 0);
                tick();
            end
            Start = 1'b0;
            Abort = 1'b0;
        end

        // Reset during EXEC, then a long run without HALT to saturate the count.
        auto_done = 1'b0;
        Done = 1'b0;
        if (m.mode == M_GAP || m.mode == M_RUN) go_idle();
        for (int a = 0; a < 32; a++) begin
            w = 9'($urandom);
            rom[a] = (w == HALT) ? 9'h000 : w;
        end
        Start = 1'b1;
        wait_run(n);
        check("t6_in_exec", Run, 1);
        #2 Resetn = 1'b0;
        #1;
        check("t6_rst_run",    Run,         0);
        check("t6_rst_din",    DIN,         0);
        check("t6_rst_busy",   Busy,        0);
        check("t6_rst_halted", Halted,      0);
        check("t6_rst_error",  Error,       0);
        check("t6_rst_pc",     pc,          0);
        check("t6_rst_count",  instr_count, 0);
        check("t6_rst_romaddr", rom_addr,   0);
        tick();
        #2 Resetn = 1'b1;
        auto_done = 1'b1;
        Start = 1'b1;
        k = 0;
        do begin
            tick();
            Start = 1'b0;
            k++;
        end while (m.completed < 16'd300 && k < 20000);
        check("t6_budget", k < 20000, 1);
        check("t6_saturate", instr_count, 255);
        check("t6_busy", Busy, 1);
        auto_done = 1'b0;
        Done = 1'b0;
        go_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
